// File: rtl/key_bounce_gen.sv
// key_bounce_gen: emulated mechanical key pin with timed bounce on press/release (optional KEY_BOUNCE_RANDOM_EN for LFSR toggle spacing)
module key_bounce_gen #(
  parameter logic [15:0] T1MS       = 16'd20000,
  parameter logic [4:0]  BOUNCE_MS  = 5'd10,
  parameter logic [15:0] TOGGLE_CYC = 16'd2000,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic CLK,
  input  logic RST,
  input  logic Press_Req,
  input  logic Release_Req,
  output logic Key_Pin,
  output logic Busy,
  output logic Done
);
  typedef enum logic [1:0] {UP, BOUNCE_DN, DOWN, BOUNCE_UP} state_t;
  state_t state_q, state_d;
  logic [15:0] cyc_cnt_q, cyc_cnt_d, tog_cnt_q, tog_cnt_d, tog_lim;
  logic [4:0] ms_cnt_q, ms_cnt_d;
  logic key_q, key_d, busy_q, busy_d, done_q, done_d;
  logic start, bouncing, cyc_wrap, exit_now, toggle_now;
`ifdef KEY_BOUNCE_RANDOM_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [15:0] tog_lim_q, tog_lim_d;
  logic unused_tog;
  assign unused_tog = ^TOGGLE_CYC;
  assign tog_lim = tog_lim_q;
  // LFSR free-runs; toggle interval is re-drawn on bounce entry and after every toggle
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    tog_lim_d = (start || toggle_now) ? {8'd0, lfsr_q[3:0], 4'b0} + 16'd1 : tog_lim_q;
  end
  // LFSR and interval registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lfsr_q <= LFSR_SEED;
      tog_lim_q <= 16'd1;
    end else begin
      lfsr_q <= lfsr_d;
      tog_lim_q <= tog_lim_d;
    end
  end
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign tog_lim = TOGGLE_CYC;
`endif
  // Next-state: accept only the request legal for the stable state; exit beats toggle
  always_comb begin
    start = (state_q == UP && Press_Req) || (state_q == DOWN && Release_Req);
    bouncing = state_q == BOUNCE_DN || state_q == BOUNCE_UP;
    cyc_wrap = cyc_cnt_q == T1MS - 16'd1;
    exit_now = bouncing && cyc_wrap && ms_cnt_q == BOUNCE_MS - 5'd1;
    toggle_now = bouncing && !exit_now && tog_cnt_q == tog_lim - 16'd1;
    state_d = start ? (state_q == UP ? BOUNCE_DN : BOUNCE_UP)
            : exit_now ? (state_q == BOUNCE_DN ? DOWN : UP) : state_q;
    key_d = start ? (state_q == DOWN) : exit_now ? (state_q == BOUNCE_UP)
          : toggle_now ? ~key_q : key_q;
    busy_d = start || (bouncing && !exit_now);
    done_d = exit_now;
    cyc_cnt_d = (start || exit_now || (bouncing && cyc_wrap)) ? 16'd0 : bouncing ? cyc_cnt_q + 16'd1 : cyc_cnt_q;
    ms_cnt_d = (start || exit_now) ? 5'd0 : (bouncing && cyc_wrap) ? ms_cnt_q + 5'd1 : ms_cnt_q;
    tog_cnt_d = (start || exit_now || toggle_now) ? 16'd0 : bouncing ? tog_cnt_q + 16'd1 : tog_cnt_q;
  end
  // State, counters and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= UP;
      cyc_cnt_q <= 16'd0;
      ms_cnt_q <= 5'd0;
      tog_cnt_q <= 16'd0;
      key_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      ms_cnt_q <= ms_cnt_d;
      tog_cnt_q <= tog_cnt_d;
      key_q <= key_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign Key_Pin = key_q;
  assign Busy = busy_q;
  assign Done = done_q;
endmodule

// File: tb/tb_key_bounce_gen.sv
// tb_key_bounce_gen: directed and random check of key_bounce_gen against an arithmetic timeline model
module tb_key_bounce_gen;
  localparam int T1 = 10, BM = 3, TG = 4, N = T1 * BM;
  logic CLK = 1'b0, RST = 1'b1, Press_Req = 1'b0, Release_Req = 1'b0;
  logic Key_Pin, Busy, Done;
  int checks = 0, errors = 0;
  int m_st = 0, m_j = 0;
  bit m_press = 1'b0, m_pin = 1'b1, m_busy = 1'b0, m_done = 1'b0;

  key_bounce_gen #(.T1MS(16'd10), .BOUNCE_MS(5'd3), .TOGGLE_CYC(16'd4), .LFSR_SEED(8'hA5)) dut (
    .CLK(CLK), .RST(RST), .Press_Req(Press_Req), .Release_Req(Release_Req),
    .Key_Pin(Key_Pin), .Busy(Busy), .Done(Done));

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  // Model: a bounce is a timeline j=0..N after the accepted request edge;
  // pin starts at the target level and has flipped floor(j/TG) times, then settles at j=N.
  initial forever begin
    @(posedge CLK or posedge RST);
    if (RST) begin
      m_st = 0; m_pin = 1'b1; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_st == 1) begin
        m_j++;
        if (m_j == N) begin
          m_st = m_press ? 2 : 0;
          m_done = 1'b1;
        end
      end else if (m_st == 0 && Press_Req) begin
        m_st = 1; m_press = 1'b1; m_j = 0;
      end else if (m_st == 2 && Release_Req) begin
        m_st = 1; m_press = 1'b0; m_j = 0;
      end
      m_busy = (m_st == 1);
      m_pin = m_busy ? ((!m_press) ^ ((m_j / TG) % 2 == 1)) : (m_st != 2);
    end
  end

  initial forever begin
    @(negedge CLK);
    chk("model_pin", Key_Pin, m_pin);
    chk("model_busy", Busy, m_busy);
    chk("model_done", Done, m_done);
  end

  // Issue a one-edge request, then step through the bounce checking literal timeline points
  task automatic bounce_literals(input bit press, input bit extra_reqs);
    bit tgt = press ? 1'b0 : 1'b1;
    if (press) Press_Req = 1'b1; else Release_Req = 1'b1;
    tick();
    Press_Req = 1'b0; Release_Req = 1'b0;
    for (int j = 0; j <= N + 1; j++) begin
      if (j == 0) begin chk("lit_start_pin", Key_Pin, tgt); chk("lit_start_busy", Busy, 1'b1); end
      if (j == 3) chk("lit_j3_pin", Key_Pin, tgt);
      if (j == 4) chk("lit_j4_pin", Key_Pin, ~tgt);
      if (j == 8) chk("lit_j8_pin", Key_Pin, tgt);
      if (j == 28) chk("lit_j28_pin", Key_Pin, ~tgt);
      if (j == 29) begin chk("lit_j29_pin", Key_Pin, ~tgt); chk("lit_j29_busy", Busy, 1'b1); chk("lit_j29_done", Done, 1'b0); end
      if (j == 30) begin chk("lit_settle_pin", Key_Pin, tgt); chk("lit_settle_busy", Busy, 1'b0); chk("lit_settle_done", Done, 1'b1); end
      if (j == 31) begin chk("lit_after_done", Done, 1'b0); chk("lit_after_pin", Key_Pin, tgt); end
      if (j <= N) begin
        Press_Req = extra_reqs && (j == 4);
        Release_Req = extra_reqs && (j == 9);
      end
      if (j <= N) tick();
      Press_Req = 1'b0; Release_Req = 1'b0;
    end
  endtask

  initial begin
    tick(3);
    RST = 1'b0;
    tick();
    chk("reset_pin", Key_Pin, 1'b1);
    chk("reset_busy", Busy, 1'b0);
    chk("reset_done", Done, 1'b0);
    Release_Req = 1'b1;
    tick();
    Release_Req = 1'b0;
    chk("release_in_up_pin", Key_Pin, 1'b1);
    chk("release_in_up_busy", Busy, 1'b0);
    tick(2);
    bounce_literals(1'b1, 1'b0);
    tick(3);
    bounce_literals(1'b0, 1'b0);
    tick(2);
    bounce_literals(1'b1, 1'b1);
    tick(2);
    bounce_literals(1'b0, 1'b0);
    tick(2);
    Press_Req = 1'b1;
    tick(15);
    Press_Req = 1'b0;
    #1 RST = 1'b1;
    #1;
    chk("async_rst_pin", Key_Pin, 1'b1);
    chk("async_rst_busy", Busy, 1'b0);
    chk("async_rst_done", Done, 1'b0);
    tick();
    RST = 1'b0;
    tick();
    bounce_literals(1'b1, 1'b0);
    tick();
    Press_Req = 1'b1; Release_Req = 1'b1;
    tick();
    Press_Req = 1'b0; Release_Req = 1'b0;
    chk("both_from_down_pin", Key_Pin, 1'b1);
    chk("both_from_down_busy", Busy, 1'b1);
    tick(N + 2);
    Press_Req = 1'b1; Release_Req = 1'b1;
    tick();
    Press_Req = 1'b0; Release_Req = 1'b0;
    chk("both_in_up_pin", Key_Pin, 1'b0);
    chk("both_in_up_busy", Busy, 1'b1);
    tick(N + 2);
    for (int c = 0; c < 3000; c++) begin
      Press_Req = ($urandom_range(0, 15) == 0);
      Release_Req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #($urandom_range(0, 4)) RST = 1'b1;
        tick();
        RST = 1'b0;
      end else tick();
    end
    Press_Req = 1'b0; Release_Req = 1'b0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_bounce_gen.md
Name: key_bounce_gen

Overview:
Virtual-key stimulus source that drives a mechanical-style key pin for the key debounce/delay path. On a press or release request it emits a bouncing waveform for a programmable number of milliseconds, then settles the pin at the stable level. It sits ahead of the edge detector and debouncer in virtual-key test builds. It lets the on-chip debounce chain be exercised with no physical key.

Parameters:
T1MS, 16'd20000, clock cycles per 1 ms (20 MHz clock).
BOUNCE_MS, 5'd10, bounce duration in ms for each press or release; legal range 1..31.
TOGGLE_CYC, 16'd2000, cycles between pin toggles during bounce (fixed mode); must be ≥1 and < T1MS*BOUNCE_MS.
LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero (used only with the optional feature).

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous, active-high reset.
Press_Req  input  1  one-cycle request to start a key press.
Release_Req  input  1  one-cycle request to start a key release.
Key_Pin  output  1  emulated key pin; 1 = released (idle), 0 = pressed.
Busy  output  1  high while in either bounce state.
Done  output  1  one-cycle pulse when the pin settles at its stable level.

Behaviour:
- Reset (async, RST=1): state=UP, Key_Pin=1, Busy=0, Done=0, all counters 0, LFSR=LFSR_SEED. Reset mid-bounce aborts immediately to these values.
- States: UP (stable released), BOUNCE_DN, DOWN (stable pressed), BOUNCE_UP.
- UP: Press_Req=1 at edge k moves to BOUNCE_DN. At edge k: Key_Pin<=0, Busy<=1, cyc_cnt/ms_cnt/tog_cnt<=0. Release_Req is ignored in UP.
- DOWN: Release_Req=1 at edge k moves to BOUNCE_UP. At edge k: Key_Pin<=1, Busy<=1, counters<=0. Press_Req is ignored in DOWN.
- Requests arriving in a bounce state are dropped, not queued. If both requests are high in the same cycle, only the one legal for the current state is acted on.
- Bounce timing:
  - cyc_cnt counts 0..T1MS-1; on wrap, ms_cnt increments.
  - Exit condition: ms_cnt==BOUNCE_MS-1 and cyc_cnt==T1MS-1. This is edge k+BOUNCE_MS*T1MS.
  - On exit: Key_Pin<=target level (0 for BOUNCE_DN, 1 for BOUNCE_UP), Busy<=0, Done<=1 for one cycle. The state moves to DOWN or UP respectively.
- Toggling:
  - tog_cnt counts 0..TOGGLE_CYC-1. At the cycle where it equals TOGGLE_CYC-1, Key_Pin is inverted and tog_cnt wraps to 0.
  - Exit has priority over a toggle on the same cycle.
- Done is 0 in every cycle except the exit cycle+1 (registered). Busy and Key_Pin are registered outputs.
- Counter widths: cyc_cnt 16 b, ms_cnt 5 b, tog_cnt 16 b. No counter advances in UP or DOWN.
- Total press-to-settle latency is exactly BOUNCE_MS*T1MS cycles from the request edge.

Optional Feature:
KEY_BOUNCE_RANDOM_EN:
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every clock. The toggle interval is reloaded at each bounce entry and each toggle as {lfsr[3:0],4'b0}+1 cycles, replacing TOGGLE_CYC. Exit timing is unchanged.
- Undefined: the LFSR is absent and the interval is fixed at TOGGLE_CYC.

Test Plan:
1. Sim params T1MS=10, BOUNCE_MS=3, TOGGLE_CYC=4; Press_Req at edge k -> Key_Pin=0 at k; toggles at k+4,8,...,28 (ends 1); Key_Pin=0, state DOWN, Done pulse at k+30; Busy high k..k+29.
2. From DOWN, Release_Req at edge m -> Key_Pin=1 at m; toggles every 4 cycles; Key_Pin=1, Done pulse at m+30; returns to UP.
3. Press_Req repeated at k+5 and Release_Req at k+10 during BOUNCE_DN -> ignored; settle still at k+30, pin 0.
4. Assert RST at k+15 mid-bounce -> Key_Pin=1, Busy=0, Done=0 immediately (async); later Press_Req restarts a full 30-cycle bounce.
5. Press_Req and Release_Req both high in UP -> press taken (BOUNCE_DN); Release_Req in UP alone -> no change, Key_Pin stays 1.
6. With KEY_BOUNCE_RANDOM_EN, LFSR_SEED=8'hA5 -> settle still at k+30. Toggle spacing matches the LFSR-derived intervals from a reference model, and no interval is 0.
